// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches through a req/ack handshake, resolves
// halt/jump/branch controls on the ack cycle and forms the next PC.
module pc_sequencer #(
   parameter int PC_W     = 16,
   parameter int RESET_PC = 0,
   parameter int ILEN     = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            beqz_i,
   input  logic            bnez_i,
   input  logic            bgez_i,
   input  logic            bltz_i,
   input  logic            jump_i,
   input  logic            sel_pc_opa_i,
   input  logic            sel_pc_opb_i,
   input  logic [PC_W-1:0] rs_val_i,
   input  logic [PC_W-1:0] imm_i,
   input  logic [PC_W-1:0] disp_i,
   output logic [PC_W-1:0] pc_link_o,
   output logic            retire_o,
   output logic            redirect_o,
   output logic            halted_o,
   output logic            err_multi_o
);

   typedef enum logic [1:0] {
      S_RST,
      S_FETCH,
      S_STALL,
      S_HALT
   } state_e;

   localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] ILEN_W     = PC_W'(ILEN);
   localparam logic [PC_W-1:0] EVEN_MASK  = {{(PC_W-1){1'b1}}, 1'b0};

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_link_q, pc_link_d;
   logic            retire_q, retire_d;
   logic            redirect_q, redirect_d;
   logic            err_multi_q, err_multi_d;

   logic [PC_W-1:0] pc_plus;
   logic [PC_W-1:0] jump_tgt;
   logic [PC_W-1:0] br_tgt;
   logic            any_branch;
   logic            rs_zero;
   logic            rs_neg;
   logic            br_taken;
   logic            multi_flags;

   assign pc_plus     = pc_q + ILEN_W;
   assign jump_tgt    = (sel_pc_opa_i ? rs_val_i : pc_plus) + (sel_pc_opb_i ? disp_i : imm_i);
   assign br_tgt      = pc_plus + imm_i;
   assign any_branch  = beqz_i | bnez_i | bgez_i | bltz_i;
   assign rs_zero     = (rs_val_i == '0);
   assign rs_neg      = rs_val_i[PC_W-1];
   assign br_taken    = (beqz_i & rs_zero) | (bnez_i & ~rs_zero) |
                        (bltz_i & rs_neg)  | (bgez_i & ~rs_neg);
   assign multi_flags = (halt_i & jump_i) | (halt_i & any_branch) | (jump_i & any_branch);

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d     = state_q;
      pc_d        = pc_q;
      pc_link_d   = pc_link_q;
      retire_d    = 1'b0;
      redirect_d  = 1'b0;
      err_multi_d = err_multi_q;
      unique case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack_i) begin
               retire_d  = 1'b1;
               pc_link_d = pc_plus;
               if (multi_flags) err_multi_d = 1'b1;
               if (halt_i) begin
                  state_d = S_HALT;
               end else begin
                  if (jump_i) begin
                     pc_d       = jump_tgt & EVEN_MASK;
                     redirect_d = 1'b1;
                  end else if (br_taken) begin
                     pc_d       = br_tgt & EVEN_MASK;
                     redirect_d = 1'b1;
                  end else begin
                     pc_d = pc_plus & EVEN_MASK;
                  end
                  state_d = stall_i ? S_STALL : S_FETCH;
               end
            end
         end
         S_STALL: if (!stall_i) state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_RST;
         pc_q        <= RESET_PC_W;
         pc_link_q   <= RESET_PC_W + ILEN_W;
         retire_q    <= 1'b0;
         redirect_q  <= 1'b0;
         err_multi_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc_link_q   <= pc_link_d;
         retire_q    <= retire_d;
         redirect_q  <= redirect_d;
         err_multi_q <= err_multi_d;
      end
   end

   assign imem_req_o  = (state_q == S_FETCH);
   assign imem_addr_o = pc_q;
   assign pc_link_o   = pc_link_q;
   assign retire_o    = retire_q;
   assign redirect_o  = redirect_q;
   assign halted_o    = (state_q == S_HALT);
   assign err_multi_o = err_multi_q;

endmodule
